// File: rtl/sram_1rw1r_wmask.sv
// Dual-port SRAM model: port 0 read/write with byte mask, port 1 read-only.
// Both ports have pipelined reads. Define SRAM_RW_BYPASS_EN to forward a
// same-address port 0 write to a port 1 read on the same edge.
module sram_1rw1r_wmask #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 11,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                    clk0,
    input  logic                    rst0,
    input  logic                    csb0,
    input  logic                    web0,
    input  logic [DATA_WIDTH/8-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0]   addr0,
    input  logic [DATA_WIDTH-1:0]   din0,
    output logic [DATA_WIDTH-1:0]   dout0,
    output logic                    dvalid0,
    input  logic                    csb1,
    input  logic [ADDR_WIDTH-1:0]   addr1,
    output logic [DATA_WIDTH-1:0]   dout1,
    output logic                    dvalid1
);

    localparam int unsigned NUM_WMASKS = DATA_WIDTH / 8;
    localparam int unsigned RAM_DEPTH  = 2 ** ADDR_WIDTH;
    localparam int unsigned PIPE_W     = READ_LATENCY * DATA_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];

    logic                  wr_en0;
    logic                  rd_en0;
    logic                  rd_en1;
    logic [DATA_WIDTH-1:0] bmask0;
    logic [DATA_WIDTH-1:0] wr_word0;
    logic [DATA_WIDTH-1:0] rd0_word;
    logic [DATA_WIDTH-1:0] rd1_word;

    // Reset blocks all accesses sampled on its edge.
    assign wr_en0 = ~rst0 & ~csb0 & ~web0;
    assign rd_en0 = ~rst0 & ~csb0 & web0;
    assign rd_en1 = ~rst0 & ~csb1;

    for (genvar b = 0; b < NUM_WMASKS; b++) begin : g_bmask
        assign bmask0[b*8 +: 8] = {8{wmask0[b]}};
    end

    assign wr_word0 = (mem_q[addr0] & ~bmask0) | (din0 & bmask0);

    always_ff @(posedge clk0) begin
        if (wr_en0) begin
            mem_q[addr0] <= wr_word0;
        end
    end

    assign rd0_word = mem_q[addr0];

`ifdef SRAM_RW_BYPASS_EN
    assign rd1_word = (wr_en0 && (addr0 == addr1)) ? wr_word0 : mem_q[addr1];
`else
    assign rd1_word = mem_q[addr1];
`endif

    // Read pipelines: stage 0 loads at the sampling edge, the last stage is the output.
    // Data only advances behind a valid bit so the output holds between reads.
    logic [READ_LATENCY-1:0] vld0_q, vld0_d, vld0_shift;
    logic [READ_LATENCY-1:0] vld1_q, vld1_d, vld1_shift;
    logic [PIPE_W-1:0]       dat0_q, dat0_d, dat0_shift;
    logic [PIPE_W-1:0]       dat1_q, dat1_d, dat1_shift;

    for (genvar g = 0; g < READ_LATENCY; g++) begin : g_pipe
        if (g == 0) begin : g_head
            assign vld0_shift[0] = rd_en0;
            assign vld1_shift[0] = rd_en1;
            assign dat0_shift[DATA_WIDTH-1:0] = rd_en0 ? rd0_word : dat0_q[DATA_WIDTH-1:0];
            assign dat1_shift[DATA_WIDTH-1:0] = rd_en1 ? rd1_word : dat1_q[DATA_WIDTH-1:0];
        end else begin : g_tail
            assign vld0_shift[g] = vld0_q[g-1];
            assign vld1_shift[g] = vld1_q[g-1];
            assign dat0_shift[g*DATA_WIDTH +: DATA_WIDTH] = vld0_q[g-1] ?
                dat0_q[(g-1)*DATA_WIDTH +: DATA_WIDTH] : dat0_q[g*DATA_WIDTH +: DATA_WIDTH];
            assign dat1_shift[g*DATA_WIDTH +: DATA_WIDTH] = vld1_q[g-1] ?
                dat1_q[(g-1)*DATA_WIDTH +: DATA_WIDTH] : dat1_q[g*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        vld0_d = vld0_shift;
        vld1_d = vld1_shift;
        dat0_d = dat0_shift;
        dat1_d = dat1_shift;
        if (rst0) begin
            vld0_d = '0;
            vld1_d = '0;
            dat0_d = '0;
            dat1_d = '0;
        end
    end

    always_ff @(posedge clk0) begin
        vld0_q <= vld0_d;
        vld1_q <= vld1_d;
        dat0_q <= dat0_d;
        dat1_q <= dat1_d;
    end

    assign dvalid0 = vld0_q[READ_LATENCY-1];
    assign dvalid1 = vld1_q[READ_LATENCY-1];
    assign dout0   = dat0_q[(READ_LATENCY-1)*DATA_WIDTH +: DATA_WIDTH];
    assign dout1   = dat1_q[(READ_LATENCY-1)*DATA_WIDTH +: DATA_WIDTH];

endmodule

// File: tb/tb_sram_1rw1r_wmask.sv
// Directed table-driven bench for sram_1rw1r_wmask at READ_LATENCY 3.
module tb_sram_1rw1r_wmask;

    localparam int unsigned LAT = 3;

`ifdef SRAM_RW_BYPASS_EN
    localparam logic [31:0] COLL_EXP = 32'hCAFEF00D;
`else
    localparam logic [31:0] COLL_EXP = 32'h00000000;
`endif

    logic        clk0 = 1'b0;
    logic        rst0;
    logic        csb0;
    logic        web0;
    logic [3:0]  wmask0;
    logic [10:0] addr0;
    logic [31:0] din0;
    logic [31:0] dout0;
    logic        dvalid0;
    logic        csb1;
    logic [10:0] addr1;
    logic [31:0] dout1;
    logic        dvalid1;

    sram_1rw1r_wmask #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (11),
        .READ_LATENCY(LAT)
    ) dut (
        .clk0   (clk0),
        .rst0   (rst0),
        .csb0   (csb0),
        .web0   (web0),
        .wmask0 (wmask0),
        .addr0  (addr0),
        .din0   (din0),
        .dout0  (dout0),
        .dvalid0(dvalid0),
        .csb1   (csb1),
        .addr1  (addr1),
        .dout1  (dout1),
        .dvalid1(dvalid1)
    );

    always #5 clk0 = ~clk0;

    typedef struct {
        logic        wr;
        logic        port;
        logic [10:0] addr;
        logic [31:0] din;
        logic [3:0]  mask;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs [14];
    logic [31:0] pexp [4];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_d0 = 32'h0;
    logic [31:0] exp_d1 = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk0);
        #1;
    endtask

    task automatic idle();
        csb0   = 1'b1;
        web0   = 1'b1;
        wmask0 = 4'h0;
        addr0  = '0;
        din0   = '0;
        csb1   = 1'b1;
        addr1  = '0;
    endtask

    task automatic run_vec(input vec_t v);
        logic [31:0] dv;
        logic [31:0] dd;
        if (v.wr) begin
            csb0 = 1'b0; web0 = 1'b0; addr0 = v.addr; din0 = v.din; wmask0 = v.mask;
        end else if (v.port == 1'b0) begin
            csb0 = 1'b0; web0 = 1'b1; addr0 = v.addr;
        end else begin
            csb1 = 1'b0; addr1 = v.addr;
        end
        tick();
        idle();
        if (v.wr) begin
            check("wr_dvalid0", {31'b0, dvalid0}, 32'h0);
            check("wr_dvalid1", {31'b0, dvalid1}, 32'h0);
            check("wr_dout0_hold", dout0, exp_d0);
        end else begin
            for (int j = 1; j < LAT; j++) begin
                dv = v.port ? {31'b0, dvalid1} : {31'b0, dvalid0};
                check("rd_early_dvalid", dv, 32'h0);
                tick();
            end
            dv = v.port ? {31'b0, dvalid1} : {31'b0, dvalid0};
            dd = v.port ? dout1 : dout0;
            check("rd_dvalid", dv, 32'h1);
            check("rd_dout", dd, v.exp);
            if (v.port) exp_d1 = v.exp;
            else exp_d0 = v.exp;
            tick();
            dv = v.port ? {31'b0, dvalid1} : {31'b0, dvalid0};
            dd = v.port ? dout1 : dout0;
            check("rd_pulse_end", dv, 32'h0);
            check("rd_dout_hold", dd, v.exp);
        end
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 11'h005, 32'hDEADBEEF, 4'hF, 32'h0};
        vecs[1]  = '{1'b0, 1'b0, 11'h005, 32'h0, 4'h0, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 1'b0, 11'h005, 32'h11223344, 4'b0101, 32'h0};
        vecs[3]  = '{1'b0, 1'b1, 11'h005, 32'h0, 4'h0, 32'hDE22BE44};
        vecs[4]  = '{1'b1, 1'b0, 11'h005, 32'hFFFFFFFF, 4'h0, 32'h0};
        vecs[5]  = '{1'b0, 1'b0, 11'h005, 32'h0, 4'h0, 32'hDE22BE44};
        vecs[6]  = '{1'b1, 1'b0, 11'h000, 32'hA0A0A0A0, 4'hF, 32'h0};
        vecs[7]  = '{1'b1, 1'b0, 11'h001, 32'hB1B1B1B1, 4'hF, 32'h0};
        vecs[8]  = '{1'b1, 1'b0, 11'h002, 32'h00000000, 4'hF, 32'h0};
        vecs[9]  = '{1'b1, 1'b0, 11'h002, 32'hC2C2C2C2, 4'b1010, 32'h0};
        vecs[10] = '{1'b1, 1'b0, 11'h003, 32'hD3D3D3D3, 4'hF, 32'h0};
        vecs[11] = '{1'b1, 1'b0, 11'h7FF, 32'h00000000, 4'hF, 32'h0};
        vecs[12] = '{1'b0, 1'b1, 11'h7FF, 32'h0, 4'h0, 32'h00000000};
        vecs[13] = '{1'b0, 1'b0, 11'h002, 32'h0, 4'h0, 32'hC200C200};
        pexp[0] = 32'hA0A0A0A0;
        pexp[1] = 32'hB1B1B1B1;
        pexp[2] = 32'hC200C200;
        pexp[3] = 32'hD3D3D3D3;

        // Reset state
        idle();
        rst0 = 1'b1;
        tick();
        tick();
        check("rst_dout0", dout0, 32'h0);
        check("rst_dvalid0", {31'b0, dvalid0}, 32'h0);
        check("rst_dout1", dout1, 32'h0);
        check("rst_dvalid1", {31'b0, dvalid1}, 32'h0);
        rst0 = 1'b0;

        for (int i = 0; i < 14; i++) begin
            run_vec(vecs[i]);
        end

        // Same-edge write on port 0 and read on port 1 at 0x7FF
        csb0 = 1'b0; web0 = 1'b0; addr0 = 11'h7FF; din0 = 32'hCAFEF00D; wmask0 = 4'hF;
        csb1 = 1'b0; addr1 = 11'h7FF;
        tick();
        idle();
        for (int j = 1; j < LAT; j++) tick();
        check("coll_dvalid1", {31'b0, dvalid1}, 32'h1);
        check("coll_dout1", dout1, COLL_EXP);
        tick();
        run_vec('{1'b0, 1'b1, 11'h7FF, 32'h0, 4'h0, 32'hCAFEF00D});

        // Back-to-back reads on both ports
        for (int c = 0; c < 4 + int'(LAT); c++) begin
            if (c < 4) begin
                csb0 = 1'b0; web0 = 1'b1; addr0 = 11'(c);
                csb1 = 1'b0; addr1 = 11'(c);
            end else begin
                idle();
            end
            tick();
            if (c - int'(LAT - 1) >= 0 && c - int'(LAT - 1) < 4) begin
                check("pipe_dvalid1", {31'b0, dvalid1}, 32'h1);
                check("pipe_dout1", dout1, pexp[c - int'(LAT - 1)]);
                check("pipe_dvalid0", {31'b0, dvalid0}, 32'h1);
                check("pipe_dout0", dout0, pexp[c - int'(LAT - 1)]);
            end else begin
                check("pipe_idle_dvalid1", {31'b0, dvalid1}, 32'h0);
            end
        end
        check("pipe_hold_dout1", dout1, pexp[3]);
        exp_d0 = pexp[3];
        exp_d1 = pexp[3];

        // Read in flight when reset hits; write and read during reset ignored
        csb0 = 1'b0; web0 = 1'b1; addr0 = 11'h005;
        tick();
        idle();
        rst0 = 1'b1;
        csb0 = 1'b0; web0 = 1'b0; addr0 = 11'h005; din0 = 32'h0; wmask0 = 4'hF;
        csb1 = 1'b0; addr1 = 11'h005;
        tick();
        rst0 = 1'b0;
        idle();
        check("rstf_dout0", dout0, 32'h0);
        check("rstf_dvalid0", {31'b0, dvalid0}, 32'h0);
        check("rstf_dout1", dout1, 32'h0);
        check("rstf_dvalid1", {31'b0, dvalid1}, 32'h0);
        exp_d0 = 32'h0;
        exp_d1 = 32'h0;
        for (int j = 0; j <= int'(LAT); j++) begin
            tick();
            check("rstf_no_pulse0", {31'b0, dvalid0}, 32'h0);
            check("rstf_no_pulse1", {31'b0, dvalid1}, 32'h0);
        end
        run_vec('{1'b0, 1'b0, 11'h005, 32'h0, 4'h0, 32'hDE22BE44});
        run_vec('{1'b0, 1'b1, 11'h000, 32'h0, 4'h0, 32'hA0A0A0A0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_1rw1r_wmask.md
SRAM_1RW1R_WMASK -- requirements
Module: sram_1rw1r_wmask

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits; a multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 11, address width; depth RAM_DEPTH = 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter READ_LATENCY, default 1, legal range 1..4, cycles from read sample to data out.
REQ-004 SHALL derive NUM_WMASKS = DATA_WIDTH/8, one mask bit per byte.
REQ-005 SHALL have one clock and a synchronous, active-high reset, as ports clk0 and rst0.
REQ-006 clk0  input  1  clock; all state changes on its rising edge.
REQ-007 rst0  input  1  synchronous active-high reset.
REQ-008 csb0  input  1  port 0 (RW) active-low select.
REQ-009 web0  input  1  port 0 active-low write enable.
REQ-010 wmask0  input  NUM_WMASKS  port 0 byte write mask; bit i enables byte i (bits 8i+7:8i).
REQ-011 addr0  input  ADDR_WIDTH  port 0 address.
REQ-012 din0  input  DATA_WIDTH  port 0 write data.
REQ-013 dout0  output  DATA_WIDTH  port 0 read data.
REQ-014 dvalid0  output  1  port 0 read-data-valid strobe.
REQ-015 csb1  input  1  port 1 (R) active-low select.
REQ-016 addr1  input  ADDR_WIDTH  port 1 address.
REQ-017 dout1  output  DATA_WIDTH  port 1 read data.
REQ-018 dvalid1  output  1  port 1 read-data-valid strobe.

Function
REQ-019 SHALL sample all port inputs on the rising clk0 edge; no combinational input-to-output path.
REQ-020 Port 0 write (csb0=0, web0=0) SHALL update only the bytes whose wmask0 bit is 1, at the sampling edge; wmask0=0 writes nothing.
REQ-021 Port 0 read (csb0=0, web0=1) or port 1 read (csb1=0) sampled at edge N SHALL drive dout and dvalid=1 for exactly one cycle after edge N+READ_LATENCY-1, i.e. registered output after READ_LATENCY edges.
REQ-022 Reads SHALL be fully pipelined: one new read per port per cycle; back-to-back results appear in issue order with dvalid high on consecutive cycles.
REQ-023 dout0/dout1 SHALL hold the last delivered read data while dvalid is 0; a write SHALL NOT change dout0.
REQ-024 Port 0 and port 1 SHALL operate independently and concurrently; both reading the same address returns identical data.
REQ-025 Same-edge port 0 write and port 1 read of the same address SHALL return data per REQ-033/REQ-034.
REQ-026 Port 0 read of an address returns the value after all writes sampled at earlier edges.

Reset
REQ-027 While rst0=1 at an edge: dout0, dout1 SHALL become 0; dvalid0, dvalid1 SHALL become 0; all read pipeline stages SHALL be cleared.
REQ-028 rst0 SHALL take priority: writes and reads sampled with rst0=1 are ignored.
REQ-029 Reads in flight when rst0 asserts SHALL be discarded; no dvalid pulse for them after reset deasserts.
REQ-030 Memory array contents SHALL NOT be altered by reset.
REQ-031 First read SHALL be accepted at the first edge with rst0=0.

Configuration
REQ-032 Macro SRAM_RW_BYPASS_EN SHALL select write-to-read collision behaviour on same address, same edge.
REQ-033 Without SRAM_RW_BYPASS_EN: port 1 SHALL return the old (pre-write) word.
REQ-034 With SRAM_RW_BYPASS_EN: port 1 SHALL return the merged word: din0 bytes where wmask0=1, old bytes elsewhere.

Verification
REQ-035 Reset, then write addr0=0x005 din0=0xDEADBEEF wmask0=4'hF, read port 0 addr 0x005 -> dout0=0xDEADBEEF, dvalid0 high exactly one cycle, READ_LATENCY edges after read sample.
REQ-036 Partial write wmask0=4'b0101 din0=0x11223344 over 0xDEADBEEF at 0x005, read port 1 -> dout1=0xDE22BE44.
REQ-037 Same edge: port 0 writes 0xCAFEF00D full mask to 0x7FF, port 1 reads 0x7FF (old 0x0) -> dout1=0x00000000 without SRAM_RW_BYPASS_EN, 0xCAFEF00D with it.
REQ-038 READ_LATENCY=3: port 1 reads 0x000..0x003 on four consecutive edges -> four consecutive dvalid1 cycles, data in order, first 3 edges after first sample.
REQ-039 Issue port 0 read, assert rst0 next edge for one cycle -> dout0=0, dvalid0 never pulses for that read; subsequent read of 0x005 still returns pre-reset data.
